opcode_exec_unit: RTL and testbench

- Execute stage sitting directly downstream of the microcode sequencer.
- Consumes one 12-bit opcode per posedge `clk` while `opcode_valid` is high.
- Owns the 16-entry register file, performs set/copy/add/decrement/skip-if-zero, and publishes register 15 as the result stream.
- The sequencer updates opcodes on negedge; this unit samples them on posedge.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_regfile.sv | 54 +++++
 rtl/opcode_exec_unit.sv | 136 +++++++++++++
 tb/tb_opcode_exec_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: opcode values, instruction
// field positions, FSM state encoding and register-file geometry.
package cpu_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int OPC_W    = 12;

    // Instruction layout {op[11:8], a[7:4], b[3:0]}
    localparam int OP_MSB = 11;
    localparam int OP_LSB = 8;
    localparam int A_MSB  = 7;
    localparam int A_LSB  = 4;
    localparam int B_MSB  = 3;
    localparam int B_LSB  = 0;

    localparam logic [3:0] OP_SET   = 4'b0000;
    localparam logic [3:0] OP_COPY  = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_DEC   = 4'b0101;
    localparam logic [3:0] OP_SKIPZ = 4'b1001;

    typedef enum logic {
        EXEC = 1'b0,
        SKIP = 1'b1
    } exec_state_e;

    function automatic logic [3:0] op_field(input logic [OPC_W-1:0] opc);
        return opc[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] a_field(input logic [OPC_W-1:0] opc);
        return opc[A_MSB:A_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] b_field(input logic [OPC_W-1:0] opc);
        return opc[B_MSB:B_LSB];
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16-entry register file: one synchronous write port, two combinational
// read ports for the operands and a combinational debug read port.
// Cleared asynchronously while reset is low.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            // Load the write data only when this entry is addressed
            always_comb begin
                reg_d = reg_q;
                if (we && (waddr == REG_AW'(gi))) begin
                    reg_d = wdata;
                end
            end

            // Register storage with asynchronous clear
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[gi] = reg_q;
        end
    endgenerate

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/opcode_exec_unit.sv
// Execute stage: decodes one opcode per rising edge, updates the register
// file, tracks the skip-next state and mirrors register OUT_REG to result.
module opcode_exec_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              opcode_valid,
    output logic              ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              skip_pending,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              illegal_q, illegal_d;
    logic              ready_q, ready_d;

    logic [3:0]        op;
    logic [REG_AW-1:0] a_idx;
    logic [REG_AW-1:0] b_idx;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign op    = op_field(opcode);
    assign a_idx = a_field(opcode);
    assign b_idx = b_field(opcode);

    cpu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .waddr    (a_idx),
        .wdata    (wr_data),
        .raddr_a  (a_idx),
        .rdata_a  (rdata_a),
        .raddr_b  (b_idx),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Decode, next-state and write-port control; a discarded opcode in SKIP
    // has no side effect other than returning to EXEC
    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        ready_d        = 1'b1;
        wr_en          = 1'b0;
        wr_data        = '0;

        if (opcode_valid) begin
            case (state_q)
                EXEC: begin
                    case (op)
                        OP_SET: begin
                            wr_en   = 1'b1;
                            wr_data = DATA_W'(b_idx);
                        end
                        OP_COPY: begin
                            wr_en   = 1'b1;
                            wr_data = rdata_b;
                        end
                        OP_ADD: begin
                            wr_en   = 1'b1;
                            wr_data = rdata_a + rdata_b;
                        end
                        OP_DEC: begin
                            wr_en   = 1'b1;
                            wr_data = rdata_a - DATA_W'(1);
                        end
                        OP_SKIPZ: begin
                            if (rdata_b == '0) begin
                                state_d = SKIP;
                            end
                        end
                        default: begin
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                SKIP: begin
                    state_d = EXEC;
                end
                default: begin
                    state_d = EXEC;
                end
            endcase
        end

        // Mirror the output register on the same edge it is written
        if (wr_en && (a_idx == REG_AW'(OUT_REG))) begin
            result_d       = wr_data;
            result_valid_d = 1'b1;
        end
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= EXEC;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
            ready_q        <= ready_d;
        end
    end

    assign ready        = ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign illegal      = illegal_q;
    assign skip_pending = (state_q == SKIP);

endmodule

// File: tb/tb_opcode_exec_unit.sv
// Bench for opcode_exec_unit: directed scenarios plus random opcodes, with
// result pulses checked through a scoreboard queue against a reference model.
module tb_opcode_exec_unit;

    localparam int DATA_W = 8;
    localparam int MODV   = 1 << DATA_W;

    logic              clk;
    logic              reset_n;
    logic [11:0]       opcode;
    logic              opcode_valid;
    logic              ready;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              skip_pending;
    logic              illegal;
    logic [3:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_regs [16];
    bit          m_skip;
    bit          m_ill;
    int unsigned expq [$];

    opcode_exec_unit #(
        .DATA_W  (DATA_W),
        .OUT_REG (15)
    ) dut (
        .clk          (clk),
        .reset        (reset_n),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .ready        (ready),
        .result       (result),
        .result_valid (result_valid),
        .skip_pending (skip_pending),
        .illegal      (illegal),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: what one valid opcode does to the architectural state
    task automatic model_step(input logic [11:0] opc);
        int unsigned op, a, b, v;
        op = opc[11:8];
        a  = opc[7:4];
        b  = opc[3:0];
        if (m_skip) begin
            m_skip = 1'b0;
            return;
        end
        v = 0;
        case (op)
            0: v = b;
            1: v = m_regs[b];
            2: v = (m_regs[a] + m_regs[b]) % MODV;
            5: v = (m_regs[a] + MODV - 1) % MODV;
            9: begin
                if (m_regs[b] == 0) m_skip = 1'b1;
                return;
            end
            default: begin
                m_ill = 1'b1;
                return;
            end
        endcase
        m_regs[a] = v;
        if (a == 15) expq.push_back(v);
    endtask

    // Monitor: every result pulse must match the oldest expected write to r15
    always @(posedge clk) begin
        #1;
        if (result_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got result_valid=1 result=%0d expected no pulse", result);
            end else begin
                chk("pulse_value", result, expq.pop_front());
            end
        end
    end

    task automatic issue(input logic [11:0] opc);
        @(negedge clk);
        opcode       = opc;
        opcode_valid = 1'b1;
        dbg_addr     = opc[7:4];
        model_step(opc);
        @(posedge clk);
        #2;
        $display("op %03h skip=%0d ill=%0d r[%0d]=%0d result=%0d",
                 opc, skip_pending, illegal, opc[7:4], dbg_data, result);
        chk("skip_pending", skip_pending, m_skip);
        chk("illegal", illegal, m_ill);
        chk("dbg_dest", dbg_data, m_regs[opc[7:4]]);
        chk("result", result, m_regs[15]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            opcode_valid = 1'b0;
            opcode       = 12'($urandom);
            @(posedge clk);
            #2;
            chk("idle_skip", skip_pending, m_skip);
            chk("idle_result", result, m_regs[15]);
        end
    endtask

    task automatic peek(input int addr, input int unsigned exp, input string name);
        dbg_addr = 4'(addr);
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.1;
            chk("regfile", dbg_data, m_regs[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        opcode_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        expq.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_skip = 1'b0;
        m_ill  = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_skip", skip_pending, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ready", ready, 0);
        check_all_regs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk("ready_after_release", ready, 1);
        $display("reset done ready=%0d", ready);
    endtask

    function automatic logic [11:0] mk(input int op, input int a, input int b);
        return {4'(op), 4'(a), 4'(b)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned op_sel, a, b;
        int ops [5] = '{0, 1, 2, 5, 9};

        reset_n      = 1'b1;
        opcode       = '0;
        opcode_valid = 1'b0;
        dbg_addr     = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_skip = 1'b0;
        m_ill  = 1'b0;

        do_reset();

        // Some activity, including a pending skip, then a mid-stream reset
        issue(mk(0, 15, 9));
        issue(mk(0, 6, 0));
        issue(mk(9, 0, 6));
        do_reset();
        chk("skip_cleared", skip_pending, 0);

        // Fibonacci through r15
        issue(mk(0, 0, 1));
        issue(mk(0, 1, 0));
        for (int k = 0; k < 6; k++) begin
            issue(mk(1, 2, 0));
            issue(mk(2, 0, 1));
            issue(mk(1, 1, 2));
            issue(mk(1, 15, 0));
        end
        idle(1);
        peek(15, 13, "fib_final");

        // Skip: failing test, then passing test discards the next SET
        do_reset();
        issue(mk(0, 10, 1));
        issue(mk(9, 0, 10));
        chk("skipz_fail_stays", skip_pending, 0);
        issue(mk(5, 10, 0));
        peek(10, 0, "dec_to_zero");
        issue(mk(9, 0, 10));
        chk("skipz_pass", skip_pending, 1);
        issue(mk(0, 15, 7));
        peek(15, 0, "skipped_set");
        issue(mk(0, 15, 3));
        idle(1);
        peek(15, 3, "set_after_skip");

        // Skip over a SKIPZ with idle cycles in between
        issue(mk(9, 0, 10));
        idle(2);
        chk("skip_held_idle", skip_pending, 1);
        issue(mk(9, 0, 10));
        chk("skip_over_skip", skip_pending, 0);
        issue(mk(0, 15, 5));
        idle(1);
        peek(15, 5, "skip_over_skip_result");

        // Wrap-around arithmetic
        issue(mk(0, 3, 0));
        issue(mk(5, 3, 0));
        peek(3, 8'hFF, "dec_wrap");
        issue(mk(2, 3, 3));
        peek(3, 8'hFE, "add_self_wrap");
        issue(mk(0, 4, 15));
        for (int k = 0; k < 17; k++) issue(mk(2, 4, 4));

        // Illegal opcode: sticky, no register change
        issue(12'hF00);
        chk("illegal_set", illegal, 1);
        check_all_regs();
        issue(mk(0, 15, 1));
        issue(mk(3, 2, 2));
        chk("illegal_sticky", illegal, 1);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                op_sel = ops[$urandom_range(0, 4)];
                if ($urandom_range(0, 39) == 0) op_sel = $urandom_range(0, 15);
                a = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
                b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15);
                issue(mk(int'(op_sel), int'(a), int'(b)));
            end
        end
        idle(2);
        check_all_regs();
        chk("pulses_drained", expq.size(), 0);

        do_reset();
        chk("illegal_cleared", illegal, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
